instr_mem_server: RTL and testbench
===================================

INSTR_MEM_SERVER -- requirements
Module: instr_mem_server

Interface
REQ-001 Parameter DEPTH, default 128, gives the number of 32-bit instruction words stored.
REQ-002 Parameter AW, default 7, gives the word-address width; it SHALL equal clog2(DEPTH).
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port load_start, input, 1 bit: a one-cycle pulse that begins a program load at word 0.
REQ-006 Port load_valid, input, 1 bit: load_data holds a valid instruction word.
REQ-007 Port load_data, input, 32 bits: instruction word to store.
REQ-008 Port load_last, input, 1 bit: marks the final word of the program.
REQ-009 Port load_ready, output, 1 bit: the block accepts a load word this cycle.
REQ-010 Port pc, input, 32 bits: byte address from the cpu fetch stage.
REQ-011 Port inst, output, 32 bits: instruction returned to the cpu.
REQ-012 Port inst_valid, output, 1 bit: inst holds a real instruction fetched from loaded memory.
REQ-013 Port prog_len, output, AW+1 bits: number of words loaded.
REQ-014 Port err_range, output, 1 bit: sticky flag for a fetch at or beyond prog_len.
REQ-015 Port err_align, output, 1 bit: sticky flag for a fetch with pc[1:0] not equal to 0.

Function
REQ-016 The FSM SHALL have three states, IDLE, LOAD and RUN; reset SHALL place it in IDLE.
REQ-017 IDLE->LOAD on load_start; LOAD->RUN on an accepted word with load_last=1, or when the DEPTH-th word is accepted.
REQ-018 RUN->LOAD on load_start, which SHALL clear prog_len, err_range and err_align; load_start in LOAD SHALL restart at word 0.
REQ-019 load_ready SHALL be 1 only in LOAD; a word is accepted when load_valid and load_ready are both 1.
REQ-020 An accepted word SHALL be written at address prog_len, after which prog_len increments by 1; prog_len SHALL saturate at DEPTH.
REQ-021 Fetch has a 1-cycle latency: at each rising edge in RUN, inst takes the value of mem[pc[AW+1:2]] for the pc sampled at that edge.
REQ-022 In RUN, if pc[31:2] is at or beyond prog_len, inst SHALL be 32'h0 (NOP), inst_valid SHALL be 0, and err_range SHALL set.
REQ-023 In RUN, if pc[1:0] is not 0, inst SHALL be NOP, inst_valid SHALL be 0, and err_align SHALL set; this check takes priority over the range check.
REQ-024 In IDLE and LOAD, inst SHALL be NOP and inst_valid SHALL be 0, with no error set.
REQ-025 If a fetch and the last load word fall in the same cycle, the fetch SHALL return NOP; the new program is visible from the next cycle.
REQ-026 err_range and err_align SHALL clear only on reset or load_start.

Reset
REQ-027 Asserting reset SHALL immediately force: state=IDLE, inst=0, inst_valid=0, load_ready=0, prog_len=0, err_range=0, err_align=0.
REQ-028 Memory contents are not reset; words at or beyond prog_len are unreachable, so stale data is never returned.
REQ-029 Reset in the middle of a load SHALL abandon the load, and prog_len SHALL read 0.

Structure
REQ-030 The state enum and the constant NOP_INST=32'h0 SHALL live in the shared AluCtrlSig_pkg, alongside the opcodes and register names.
REQ-031 Storage SHALL be a sub-module imem_ram: DEPTH x 32, one synchronous write port and one synchronous read port, no reset.
REQ-032 The top level holds the FSM, the prog_len counter, the error flags and the output registers.

Verification
REQ-033 Reset, load_start, 10 words (last flagged), then pc=0,4,...,36 -> inst equals each word one cycle later, inst_valid=1, prog_len=10.
REQ-034 After a 10-word load, pc=40 -> inst=0, inst_valid=0, err_range=1; the flag stays 1 through later valid fetches.
REQ-035 pc=6 in RUN -> inst=0, err_align=1, err_range unchanged; pc=5 with prog_len=1 -> only err_align sets.
REQ-036 Load 128 words without load_last -> LOAD exits after the 128th word, load_ready drops, prog_len=128, pc=508 returns word 127.
REQ-037 Reset asserted after 3 of 5 load words -> outputs go to reset values asynchronously; a new 2-word load returns correct words at pc=0 and pc=4, and pc=8 gives err_range.
REQ-038 load_valid toggling 1,0,1 during LOAD -> only the cycles with handshake high store words, at consecutive addresses.

Source files
------------

// File: rtl/AluCtrlSig_pkg.sv
// Shared CPU control package: opcodes, register names, and the
// instruction-memory server state encoding and NOP constant.
package AluCtrlSig_pkg;

  // Instruction-memory server control states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } imem_state_e;

  // Returned whenever no real instruction is available
  localparam logic [31:0] NOP_INST = 32'h0000_0000;

  // Base opcodes (instr[6:0])
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // ABI register names
  typedef enum logic [4:0] {
    R_ZERO = 5'd0,  R_RA = 5'd1,  R_SP = 5'd2,  R_GP = 5'd3,
    R_TP   = 5'd4,  R_T0 = 5'd5,  R_T1 = 5'd6,  R_T2 = 5'd7,
    R_S0   = 5'd8,  R_S1 = 5'd9,  R_A0 = 5'd10, R_A1 = 5'd11
  } reg_name_e;

endpackage

// File: rtl/imem_ram.sv
// Instruction storage: DEPTH x 32, one synchronous write port and one
// synchronous read port. Contents are deliberately not reset.
module imem_ram #(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Write port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Read port: data for the address sampled at this edge
  always_ff @(posedge clk) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_mem_server.sv
// Instruction memory server: loads a program word stream into imem_ram,
// then serves 1-cycle-latency fetches with range and alignment checking.
module instr_mem_server
  import AluCtrlSig_pkg::*;
#(
  parameter int DEPTH = 128,
  parameter int AW    = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_start,
  input  logic        load_valid,
  input  logic [31:0] load_data,
  input  logic        load_last,
  output logic        load_ready,
  input  logic [31:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [AW:0] prog_len,
  output logic        err_range,
  output logic        err_align
);

  localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);
  localparam logic [AW:0] LAST_IDX = (AW+1)'(DEPTH - 1);

  imem_state_e r_state;
  logic [AW:0] r_prog_len;
  logic        r_err_range;
  logic        r_err_align;
  logic        r_fetch_ok;   // RAM output at this cycle is a real instruction

  logic        w_in_load;
  logic        w_we;
  logic [29:0] w_word_idx;
  logic [29:0] w_len_ext;
  logic        w_misalign;
  logic        w_out_range;
  logic [31:0] w_rdata;

  assign w_in_load   = (r_state == ST_LOAD);
  // load_start in LOAD restarts the program, so the word in that cycle is dropped
  assign w_we        = w_in_load & load_valid & ~load_start;
  assign w_word_idx  = pc[31:2];
  assign w_len_ext   = 30'(r_prog_len);
  assign w_misalign  = (pc[1:0] != 2'b00);
  assign w_out_range = (w_word_idx >= w_len_ext);

  imem_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (r_prog_len[AW-1:0]),
    .i_wdata (load_data),
    .i_raddr (pc[AW+1:2]),
    .o_rdata (w_rdata)
  );

  // Control FSM, program length counter, sticky error flags, fetch qualifier
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_prog_len  <= '0;
      r_err_range <= 1'b0;
      r_err_align <= 1'b0;
      r_fetch_ok  <= 1'b0;
    end else begin
      r_fetch_ok <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_state     <= ST_LOAD;
            r_prog_len  <= '0;
            r_err_range <= 1'b0;
            r_err_align <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (load_start) begin
            r_prog_len  <= '0;
            r_err_range <= 1'b0;
            r_err_align <= 1'b0;
          end else if (load_valid) begin
            if (r_prog_len != FULL_LEN) r_prog_len <= r_prog_len + (AW+1)'(1);
            if (load_last || r_prog_len == LAST_IDX) r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (load_start) begin
            r_state     <= ST_LOAD;
            r_prog_len  <= '0;
            r_err_range <= 1'b0;
            r_err_align <= 1'b0;
          end else if (w_misalign) begin
            r_err_align <= 1'b1;
          end else if (w_out_range) begin
            r_err_range <= 1'b1;
          end else begin
            r_fetch_ok <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign load_ready = w_in_load;
  assign inst       = r_fetch_ok ? w_rdata : NOP_INST;
  assign inst_valid = r_fetch_ok;
  assign prog_len   = r_prog_len;
  assign err_range  = r_err_range;
  assign err_align  = r_err_align;

endmodule

// File: tb/tb_instr_mem_server.sv
// Bench for instr_mem_server: directed scenarios plus randomized loads and
// fetches, checked against a word-array reference model.
module tb_instr_mem_server;

  localparam int DEPTH = 128;
  localparam int AW    = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_start;
  logic        load_valid;
  logic [31:0] load_data;
  logic        load_last;
  logic        load_ready;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic [AW:0] prog_len;
  logic        err_range;
  logic        err_align;

  int vectors = 0;
  int errors  = 0;

  // Reference model: program image, length, load progress and sticky flags
  logic [31:0] m_mem [DEPTH];
  int          m_len;
  bit          m_loading;
  bit          m_started;
  bit          m_err_range;
  bit          m_err_align;

  instr_mem_server #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .pc         (pc),
    .inst       (inst),
    .inst_valid (inst_valid),
    .prog_len   (prog_len),
    .err_range  (err_range),
    .err_align  (err_align)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_len = 0; m_loading = 0; m_started = 0; m_err_range = 0; m_err_align = 0;
  endtask

  task automatic check_status(input string tag);
    vectors++;
    if (prog_len !== (AW+1)'(m_len) || load_ready !== m_loading ||
        err_range !== m_err_range || err_align !== m_err_align) begin
      errors++;
      $display("FAIL %s: got len=%0d rdy=%b er=%b ea=%b, want len=%0d rdy=%b er=%b ea=%b",
               tag, prog_len, load_ready, err_range, err_align,
               m_len, m_loading, m_err_range, m_err_align);
    end
  endtask

  task automatic start_load;
    load_start = 1'b1;
    step;
    load_start = 1'b0;
    m_len = 0; m_loading = 1; m_started = 1; m_err_range = 0; m_err_align = 0;
  endtask

  // One load cycle; the model decides whether the word is taken
  task automatic drive_word(input bit v, input logic [31:0] d, input bit last);
    load_valid = v; load_data = d; load_last = last;
    vectors++;
    if (load_ready !== m_loading) begin
      errors++;
      $display("FAIL load_ready: got %b want %b", load_ready, m_loading);
    end
    step;
    if (v && m_loading) begin
      m_mem[m_len] = d;
      m_len++;
      if (last || m_len == DEPTH) m_loading = 0;
    end
    load_valid = 1'b0; load_last = 1'b0;
  endtask

  task automatic do_load(input int n, input bit use_last, input bit gaps);
    int i = 0;
    int budget = 0;
    start_load();
    while (i < n && m_loading) begin
      bit v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      bit acc = v;
      drive_word(v, $urandom, use_last && (i == n - 1));
      if (acc) i++;
      budget++;
      if (budget > 4000) begin
        errors++;
        $display("FAIL load_budget: loaded %0d of %0d words", i, n);
        break;
      end
    end
    check_status("after_load");
  endtask

  task automatic fetch(input logic [31:0] a);
    logic [31:0] exp_inst = 32'h0;
    bit          exp_v    = 0;
    pc = a;
    step;
    if (m_started && !m_loading) begin
      if (a[1:0] != 2'b00) m_err_align = 1;
      else if ((a >> 2) >= 32'(m_len)) m_err_range = 1;
      else begin exp_inst = m_mem[a >> 2]; exp_v = 1; end
    end
    vectors++;
    if (inst !== exp_inst || inst_valid !== exp_v) begin
      errors++;
      $display("FAIL fetch pc=%h: got inst=%h v=%b want inst=%h v=%b",
               a, inst, inst_valid, exp_inst, exp_v);
    end
    check_status("fetch_flags");
  endtask

  task automatic test_reset;
    reset = 1'b1; load_start = 0; load_valid = 0; load_data = 0; load_last = 0; pc = 0;
    model_reset();
    step; step;
    reset = 1'b0;
    step;
    vectors++;
    if (inst !== 32'h0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_inst: got %h/%b want 0/0", inst, inst_valid);
    end
    check_status("reset_state");
    fetch(32'h0);  // IDLE: NOP, no error
  endtask

  task automatic test_basic_load;
    pc = 32'h0;
    do_load(10, 1, 0);
    // fetch at pc=0 coincided with the last word: must have returned NOP
    vectors++;
    if (inst !== 32'h0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL last_word_fetch: got %h/%b want 0/0", inst, inst_valid);
    end
    for (int k = 0; k < 10; k++) fetch(32'(k * 4));
  endtask

  task automatic test_range;
    fetch(32'd40);
    fetch(32'd0);
    fetch(32'd36);
    fetch(32'hFFFF_FFFC);
  endtask

  task automatic test_align;
    fetch(32'd6);
    fetch(32'd8);
    do_load(1, 1, 0);
    fetch(32'd5);
    fetch(32'd0);
  endtask

  task automatic test_full_load;
    do_load(DEPTH, 0, 0);
    fetch(32'd508);
    fetch(32'd0);
    fetch(32'd512);
  endtask

  task automatic test_reset_midload;
    start_load();
    for (int k = 0; k < 3; k++) drive_word(1'b1, $urandom, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (inst !== 32'h0 || inst_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_inst: got %h/%b want 0/0", inst, inst_valid);
    end
    check_status("async_reset");
    step;
    reset = 1'b0;
    do_load(2, 1, 0);
    fetch(32'd0);
    fetch(32'd4);
    fetch(32'd8);
  endtask

  task automatic test_valid_gaps;
    start_load();
    drive_word(1'b1, 32'hAAAA_0001, 1'b0);
    drive_word(1'b0, 32'hDEAD_BEEF, 1'b0);
    drive_word(1'b1, 32'hAAAA_0002, 1'b0);
    drive_word(1'b0, 32'hDEAD_BEEF, 1'b1);
    drive_word(1'b1, 32'hAAAA_0003, 1'b1);
    check_status("gap_load");
    for (int k = 0; k < 4; k++) fetch(32'(k * 4));
  endtask

  task automatic test_random;
    for (int r = 0; r < 6; r++) begin
      do_load($urandom_range(1, 40), 1, 1);
      for (int k = 0; k < 30; k++) begin
        int sel = $urandom_range(0, 9);
        logic [31:0] a;
        if (sel < 6)      a = 32'($urandom_range(0, m_len - 1) * 4);
        else if (sel < 8) a = 32'($urandom_range(0, (m_len + 4) * 4));
        else              a = $urandom;
        fetch(a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_range();
    test_align();
    test_full_load();
    test_reset_midload();
    test_valid_gaps();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
